ov7670_capture: RTL and testbench

Writer side of the 240×320 RGB565 frame buffer. The block samples the OV7670 DVP bus (CAM_PCLK, CAM_VSYNC, CAM_HREF, CAM_DATA) inside the CLK_40M domain and pairs bytes into 16-bit pixels. It issues single-cycle write strobes, with linear addresses, into the dual-port buffer that the VGA scan-out block reads. It also reports frame completion and frame-geometry errors.

---
 rtl/ov7670_capture.sv | 186 ++++++++++++++++++
 tb/tb_ov7670_capture.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_capture.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// ov7670_capture : OV7670 DVP byte-pair capture into a linear RGB565 buffer
// Rev 1.0
// ============================================================================
module ov7670_capture #(
    parameter int X_SIZE    = 240,
    parameter int Y_SIZE    = 320,
    parameter int ADD_RANGE = X_SIZE * Y_SIZE - 1
) (
    input  logic        clk_40m_i,
    input  logic        rst_n_i,
    input  logic        cam_pclk_i,
    input  logic        cam_vsync_i,
    input  logic        cam_href_i,
    input  logic [7:0]  cam_data_i,
    input  logic        capture_en_i,
    output logic        wr_en_o,
    output logic [16:0] wr_address_o,
    output logic [15:0] wr_data_o,
    output logic        frame_done_o,
    output logic        frame_err_o,
    output logic        busy_o
);

    localparam int COL_W = $clog2(X_SIZE + 2);
    localparam int ROW_W = $clog2(Y_SIZE + 2);
    localparam logic [COL_W-1:0] c_x_size    = COL_W'(X_SIZE);
    localparam logic [COL_W-1:0] c_col_max   = COL_W'(X_SIZE + 1);
    localparam logic [ROW_W-1:0] c_y_size    = ROW_W'(Y_SIZE);
    localparam logic [ROW_W-1:0] c_row_max   = ROW_W'(Y_SIZE + 1);
    localparam logic [16:0]      c_stride    = 17'(X_SIZE);
    localparam logic [16:0]      c_add_range = 17'(ADD_RANGE);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_CAPTURE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       pclk_q, vsync_q, href_q;   // bit0 = s1, bit1 = s2, bit2 = s3
    logic [7:0]       data_s1_q, data_s2_q;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [16:0]      row_base_q, row_base_d;
    logic             phase_q, phase_d;
    logic [7:0]       hi_q, hi_d;
    logic             err_q, err_d;
    logic             wr_en_q, wr_en_d;
    logic [16:0]      wr_addr_q, wr_addr_d;
    logic [15:0]      wr_data_q, wr_data_d;
    logic             done_q, done_d;
    logic             ferr_q, ferr_d;
    logic [16:0]      w_addr;

    logic w_pclk_rise, w_vsync_fall, w_vsync_rise, w_href_rise, w_href_fall;

    assign w_pclk_rise  =  pclk_q[1]  & ~pclk_q[2];
    assign w_vsync_fall = ~vsync_q[1] &  vsync_q[2];
    assign w_vsync_rise =  vsync_q[1] & ~vsync_q[2];
    assign w_href_rise  =  href_q[1]  & ~href_q[2];
    assign w_href_fall  = ~href_q[1]  &  href_q[2];

    always_ff @(posedge clk_40m_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pclk_q     <= '0;
            vsync_q    <= '0;
            href_q     <= '0;
            data_s1_q  <= '0;
            data_s2_q  <= '0;
            state_q    <= S_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            phase_q    <= 1'b0;
            hi_q       <= '0;
            err_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            pclk_q     <= {pclk_q[1:0], cam_pclk_i};
            vsync_q    <= {vsync_q[1:0], cam_vsync_i};
            href_q     <= {href_q[1:0], cam_href_i};
            data_s1_q  <= cam_data_i;
            data_s2_q  <= data_s1_q;
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            phase_q    <= phase_d;
            hi_q       <= hi_d;
            err_q      <= err_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
        end
    end

    // Later events in this block see the _d values of earlier ones, which
    // orders line start, byte capture, line end and frame end in one cycle.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        phase_d    = phase_q;
        hi_d       = hi_q;
        err_d      = err_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        ferr_d     = 1'b0;
        w_addr     = '0;

        case (state_q)
            S_IDLE: begin
                if (w_vsync_fall && capture_en_i) begin
                    state_d    = S_CAPTURE;
                    col_d      = '0;
                    row_d      = '0;
                    row_base_d = '0;
                    phase_d    = 1'b0;
                    err_d      = 1'b0;
                end
            end
            S_CAPTURE: begin
                if (w_href_rise) begin
                    col_d   = '0;
                    phase_d = 1'b0;
                end
                // A PCLK edge coinciding with the HREF fall still belongs to the line.
                if (w_pclk_rise && (href_q[1] || w_href_fall)) begin
                    if (!phase_d) begin
                        hi_d    = data_s2_q;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        w_addr  = row_base_q + 17'(col_d);
                        if ((col_d < c_x_size) && (row_q < c_y_size) && (w_addr <= c_add_range)) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = w_addr;
                            wr_data_d = {hi_q, data_s2_q};
                        end
                        if (col_d != c_col_max) begin
                            col_d = col_d + 1'b1;
                        end
                    end
                end
                if (w_href_fall) begin
                    if ((col_d != c_x_size) || phase_d) begin
                        err_d = 1'b1;
                    end
                    phase_d = 1'b0;
                    if (row_q != c_row_max) begin
                        row_d = row_q + 1'b1;
                    end
                    if (row_q < c_y_size) begin
                        row_base_d = row_base_q + c_stride;
                    end
                end
                if (w_vsync_rise) begin
                    done_d  = 1'b1;
                    ferr_d  = err_d || (row_d != c_y_size);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_en_o      = wr_en_q;
    assign wr_address_o = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign frame_done_o = done_q;
    assign frame_err_o  = ferr_q;
    assign busy_o       = (state_q == S_CAPTURE);

endmodule
`default_nettype wire

// File: tb/tb_ov7670_capture.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// tb_ov7670_capture : directed frame-level bench on a reduced 8x6 geometry
// Rev 1.0
// ============================================================================
module tb_ov7670_capture;

    localparam int XS = 8;
    localparam int YS = 6;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        pclk   = 1'b0;
    logic        vsync  = 1'b1;
    logic        href   = 1'b0;
    logic        cap_en = 1'b0;
    logic [7:0]  data   = 8'h00;
    logic        wr_en;
    logic [16:0] wr_addr;
    logic [15:0] wr_data;
    logic        done;
    logic        ferr;
    logic        busy;

    int total = 0;
    int bad   = 0;

    int mon_addr[$];
    int mon_data[$];
    int exp_addr[$];
    int exp_data[$];
    int done_cnt    = 0;
    int err_at_done = 0;
    int b2b         = 0;
    logic prev_en   = 1'b0;
    int line_len[0:15];

    always #5 clk = ~clk;

    ov7670_capture #(
        .X_SIZE    (XS),
        .Y_SIZE    (YS),
        .ADD_RANGE (XS * YS - 1)
    ) dut (
        .clk_40m_i    (clk),
        .rst_n_i      (rst_n),
        .cam_pclk_i   (pclk),
        .cam_vsync_i  (vsync),
        .cam_href_i   (href),
        .cam_data_i   (data),
        .capture_en_i (cap_en),
        .wr_en_o      (wr_en),
        .wr_address_o (wr_addr),
        .wr_data_o    (wr_data),
        .frame_done_o (done),
        .frame_err_o  (ferr),
        .busy_o       (busy)
    );

    always @(negedge clk) begin
        if (wr_en) begin
            mon_addr.push_back(int'(wr_addr));
            mon_data.push_back(int'(wr_data));
        end
        if (wr_en && prev_en) b2b++;
        prev_en = wr_en;
        if (done) begin
            done_cnt++;
            err_at_done = int'(ferr);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        mon_addr.delete();
        mon_data.delete();
        done_cnt    = 0;
        err_at_done = 0;
        b2b         = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        pclk = 1'b0;
        data = b;
        cyc(3);
        pclk = 1'b1;
        cyc(3);
    endtask

    task automatic send_line(input int r, input int len);
        href = 1'b1;
        cyc(2);
        for (int b = 0; b < len; b++) begin
            send_byte((b % 2 == 0) ? 8'(r) : 8'(b / 2));
        end
        pclk = 1'b0;
        href = 1'b0;
        cyc(4);
    endtask

    task automatic start_frame(input logic en);
        clear_mon();
        cap_en = en;
        vsync  = 1'b0;
        cyc(4);
    endtask

    task automatic end_frame();
        vsync = 1'b1;
        cyc(8);
    endtask

    task automatic set_lines(input int len);
        for (int i = 0; i < 16; i++) line_len[i] = len;
    endtask

    // Expected writes: pixel c of line r lands at r*XS+c carrying {r, c}.
    task automatic build_expect(input int nl);
        exp_addr.delete();
        exp_data.delete();
        for (int r = 0; r < nl; r++) begin
            for (int c = 0; c < line_len[r] / 2; c++) begin
                if (c < XS && r < YS) begin
                    exp_addr.push_back(r * XS + c);
                    exp_data.push_back((r % 256) * 256 + (c % 256));
                end
            end
        end
    endtask

    function automatic int seq_diff();
        int n;
        n = (mon_addr.size() < exp_addr.size()) ? mon_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            if (mon_addr[i] != exp_addr[i] || mon_data[i] != exp_data[i]) return i;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(3);
        total++;
        if ({wr_en, done, ferr, busy} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got %b, expected 0000", {wr_en, done, ferr, busy});
        end
        total++;
        if (wr_addr !== 17'd0) begin
            bad++;
            $display("FAIL reset_addr: got %0d, expected 0", wr_addr);
        end
        total++;
        if (wr_data !== 16'd0) begin
            bad++;
            $display("FAIL reset_data: got %h, expected 0000", wr_data);
        end
        rst_n = 1'b1;
        clear_mon();
        cyc(6);
        total++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: done_cnt=%0d busy=%b, expected 0 and 0", done_cnt, busy);
        end
    endtask

    task automatic test_nominal();
        int d;
        set_lines(2 * XS);
        start_frame(1'b1);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL nominal_busy: got %b, expected 1", busy);
        end
        cap_en = 1'b0;  // sampled only at frame start
        for (int r = 0; r < YS; r++) send_line(r, line_len[r]);
        end_frame();
        build_expect(YS);
        total++;
        if (mon_addr.size() != XS * YS) begin
            bad++;
            $display("FAIL nominal_count: got %0d, expected %0d", mon_addr.size(), XS * YS);
        end
        d = seq_diff();
        total++;
        if (d != -1) begin
            bad++;
            $display("FAIL nominal_seq: idx %0d got addr %0d data %h, expected addr %0d data %h",
                     d, mon_addr[d], mon_data[d], exp_addr[d], exp_data[d]);
        end
        total++;
        if (done_cnt != 1 || err_at_done != 0) begin
            bad++;
            $display("FAIL nominal_done: done_cnt=%0d err=%0d, expected 1 and 0", done_cnt, err_at_done);
        end
        total++;
        if (b2b != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL nominal_tail: b2b=%0d busy=%b, expected 0 and 0", b2b, busy);
        end
    endtask

    task automatic test_skip();
        set_lines(2 * XS);
        start_frame(1'b0);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL skip_busy: got %b, expected 0", busy);
        end
        for (int r = 0; r < YS; r++) send_line(r, line_len[r]);
        end_frame();
        total++;
        if (mon_addr.size() != 0 || done_cnt != 0) begin
            bad++;
            $display("FAIL skip_quiet: writes=%0d done_cnt=%0d, expected 0 and 0", mon_addr.size(), done_cnt);
        end
    endtask

    task automatic test_long_line();
        int d;
        set_lines(2 * XS);
        line_len[2] = 2 * XS + 4;
        start_frame(1'b1);
        for (int r = 0; r < YS; r++) send_line(r, line_len[r]);
        end_frame();
        build_expect(YS);
        total++;
        if (mon_addr.size() != XS * YS) begin
            bad++;
            $display("FAIL long_count: got %0d, expected %0d", mon_addr.size(), XS * YS);
        end
        d = seq_diff();
        total++;
        if (d != -1) begin
            bad++;
            $display("FAIL long_seq: idx %0d got addr %0d data %h, expected addr %0d data %h",
                     d, mon_addr[d], mon_data[d], exp_addr[d], exp_data[d]);
        end
        total++;
        if (mon_addr.size() > 3 * XS && mon_addr[3 * XS] != 3 * XS) begin
            bad++;
            $display("FAIL long_next_line: got %0d, expected %0d", mon_addr[3 * XS], 3 * XS);
        end
        total++;
        if (done_cnt != 1 || err_at_done != 1) begin
            bad++;
            $display("FAIL long_err: done_cnt=%0d err=%0d, expected 1 and 1", done_cnt, err_at_done);
        end
    endtask

    task automatic test_short_odd();
        int d;
        set_lines(2 * XS);
        line_len[0] = 2 * XS - 1;
        start_frame(1'b1);
        for (int r = 0; r < 3; r++) send_line(r, line_len[r]);
        end_frame();
        build_expect(3);
        total++;
        if (mon_addr.size() != 3 * XS - 1) begin
            bad++;
            $display("FAIL short_count: got %0d, expected %0d", mon_addr.size(), 3 * XS - 1);
        end
        d = seq_diff();
        total++;
        if (d != -1) begin
            bad++;
            $display("FAIL short_seq: idx %0d got addr %0d data %h, expected addr %0d data %h",
                     d, mon_addr[d], mon_data[d], exp_addr[d], exp_data[d]);
        end
        total++;
        if (mon_addr.size() == 0 || mon_addr[mon_addr.size() - 1] != 3 * XS - 1) begin
            bad++;
            $display("FAIL short_last_addr: got %0d writes, expected last addr %0d", mon_addr.size(), 3 * XS - 1);
        end
        total++;
        if (done_cnt != 1 || err_at_done != 1) begin
            bad++;
            $display("FAIL short_err: done_cnt=%0d err=%0d, expected 1 and 1", done_cnt, err_at_done);
        end
    endtask

    task automatic test_extra_lines();
        int max_a;
        set_lines(2 * XS);
        start_frame(1'b1);
        for (int r = 0; r < YS + 2; r++) send_line(r, line_len[r]);
        end_frame();
        max_a = 0;
        foreach (mon_addr[i]) if (mon_addr[i] > max_a) max_a = mon_addr[i];
        total++;
        if (mon_addr.size() != XS * YS || max_a != XS * YS - 1) begin
            bad++;
            $display("FAIL extra_range: writes=%0d max=%0d, expected %0d and %0d",
                     mon_addr.size(), max_a, XS * YS, XS * YS - 1);
        end
        total++;
        if (done_cnt != 1 || err_at_done != 1) begin
            bad++;
            $display("FAIL extra_err: done_cnt=%0d err=%0d, expected 1 and 1", done_cnt, err_at_done);
        end
    endtask

    task automatic test_reset_mid_frame();
        int d;
        set_lines(2 * XS);
        start_frame(1'b1);
        for (int r = 0; r < 3; r++) send_line(r, line_len[r]);
        rst_n = 1'b0;
        cyc(1);
        total++;
        if ({wr_en, done, ferr, busy} !== 4'b0000 || wr_addr !== 17'd0 || wr_data !== 16'd0) begin
            bad++;
            $display("FAIL midrst_outputs: flags=%b addr=%0d data=%h, expected all zero",
                     {wr_en, done, ferr, busy}, wr_addr, wr_data);
        end
        cyc(2);
        rst_n = 1'b1;
        clear_mon();
        for (int r = 3; r < YS; r++) send_line(r, line_len[r]);
        end_frame();
        total++;
        if (mon_addr.size() != 0 || done_cnt != 0) begin
            bad++;
            $display("FAIL midrst_quiet: writes=%0d done_cnt=%0d, expected 0 and 0", mon_addr.size(), done_cnt);
        end
        start_frame(1'b1);
        for (int r = 0; r < YS; r++) send_line(r, line_len[r]);
        end_frame();
        build_expect(YS);
        d = seq_diff();
        total++;
        if (mon_addr.size() != XS * YS || d != -1) begin
            bad++;
            $display("FAIL midrst_next_frame: writes=%0d first_diff=%0d, expected %0d and -1",
                     mon_addr.size(), d, XS * YS);
        end
        total++;
        if (done_cnt != 1 || err_at_done != 0) begin
            bad++;
            $display("FAIL midrst_done: done_cnt=%0d err=%0d, expected 1 and 0", done_cnt, err_at_done);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_skip();
        test_long_line();
        test_short_odd();
        test_extra_lines();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
